// File: rtl/ahb_dphase_mux_pkg.sv
// ---------------------------------------------------------------------------
// AHB_package: types and helpers shared by the AHB data-phase mux and its
// internal default slave.
//   htrans_t       : AHB transfer type encoding
//   ds_state_t     : default-slave FSM state encoding
//   HRESP_OKAY/ERR : single-bit HRESP values
//   is_onehot()    : true when exactly one bit of a select vector is set
//                    (select vectors up to 16 bits, zero-extended by callers)
// ---------------------------------------------------------------------------
package AHB_package;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam int MAX_CHANNELS = 16;

    // Clearing the lowest set bit leaves zero only for a power of two.
    function automatic logic is_onehot(input logic [MAX_CHANNELS-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/ahb_dphase_mux_default_slave.sv
// ---------------------------------------------------------------------------
// ahb_default_slave: answers data phases that have no valid slave selected.
// Idle transfers get a zero-wait OKAY; an illegal active transfer gets the
// standard two-cycle AHB ERROR response (HREADY low then high, HRESP high).
// Ports:
//   HCLK, HRESETn : clock, async active-low reset
//   illegal       : address phase sampled this cycle is an illegal access
//   HREADY, HRESP : registered default-slave data-phase response
// ---------------------------------------------------------------------------
module ahb_default_slave
    import AHB_package::*;
(
    input  logic HCLK,
    input  logic HRESETn,
    input  logic illegal,
    output logic HREADY,
    output logic HRESP
);

    ds_state_t state;

    // Outputs are registered alongside the state so they are glitch-free
    // and change only on the clock edge (or immediately on reset).
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state  <= DS_IDLE;
            HREADY <= 1'b1;
            HRESP  <= HRESP_OKAY;
        end else begin
            case (state)
                DS_IDLE: begin
                    if (illegal) begin
                        state  <= DS_ERR1;
                        HREADY <= 1'b0;
                        HRESP  <= HRESP_ERROR;
                    end
                end
                DS_ERR1: begin
                    state  <= DS_ERR2;
                    HREADY <= 1'b1;
                    HRESP  <= HRESP_ERROR;
                end
                DS_ERR2: begin
                    // Second error cycle has HREADY high, so a new address
                    // phase is sampled here and may start another error.
                    if (illegal) begin
                        state  <= DS_ERR1;
                        HREADY <= 1'b0;
                        HRESP  <= HRESP_ERROR;
                    end else begin
                        state  <= DS_IDLE;
                        HREADY <= 1'b1;
                        HRESP  <= HRESP_OKAY;
                    end
                end
                default: begin
                    state  <= DS_IDLE;
                    HREADY <= 1'b1;
                    HRESP  <= HRESP_OKAY;
                end
            endcase
        end
    end

endmodule

// File: rtl/ahb_dphase_mux.sv
// ---------------------------------------------------------------------------
// ahb_dphase_mux: AHB slave-to-master data-phase multiplexer.
// Registers the decoder select at the address phase and steers the selected
// slave's HRDATA/HREADYOUT/HRESP back to the master during the data phase.
// Zero or multi-hot selects route to an internal default slave, which
// reports active transfers as decode errors.
// Ports:
//   HCLK, HRESETn        : clock, async active-low reset
//   HSEL_in, HTRANS      : address-phase select and transfer type
//   HREADY               : bus ready (HREADY_out fed back)
//   HRDATA_in, HREADYOUT_in, HRESP_in : per-channel slave responses
//   err_clr              : synchronous clear of decode_err / err_cnt
//   HRDATA_out, HREADY_out, HRESP_out : muxed response to the master
//   dphase_sel           : registered data-phase select
//   decode_err           : sticky illegal-access flag
//   err_cnt              : saturating illegal-access count
// Build option: define AHB_MUX_ERR_CNT_EN to add the err_cnt port/counter.
// ---------------------------------------------------------------------------
module ahb_dphase_mux
    import AHB_package::*;
#(
    parameter int CHANNEL_NUM = 4,
    parameter int DATA_W      = 32,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                                HCLK,
    input  logic                                HRESETn,
    input  logic [CHANNEL_NUM-1:0]              HSEL_in,
    input  logic [1:0]                          HTRANS,
    input  logic                                HREADY,
    input  logic [CHANNEL_NUM-1:0][DATA_W-1:0]  HRDATA_in,
    input  logic [CHANNEL_NUM-1:0]              HREADYOUT_in,
    input  logic [CHANNEL_NUM-1:0]              HRESP_in,
    input  logic                                err_clr,
    output logic [DATA_W-1:0]                   HRDATA_out,
    output logic                                HREADY_out,
    output logic                                HRESP_out,
    output logic [CHANNEL_NUM-1:0]              dphase_sel,
`ifdef AHB_MUX_ERR_CNT_EN
    output logic [ERR_CNT_W-1:0]                err_cnt,
`endif
    output logic                                decode_err
);

    htrans_t htrans;
    logic    active;
    logic    sel_ok;
    logic    illegal;
    logic    ds_hready;
    logic    ds_hresp;

    assign htrans  = htrans_t'(HTRANS);
    assign active  = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    assign sel_ok  = is_onehot(MAX_CHANNELS'(HSEL_in));
    assign illegal = HREADY && active && !sel_ok;

    // Data-phase select: a bad select parks on the default slave (zero).
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dphase_sel <= '0;
        end else if (HREADY) begin
            dphase_sel <= sel_ok ? HSEL_in : '0;
        end
    end

    // Sticky flag; a new error in the same cycle as a clear keeps it set.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            decode_err <= 1'b0;
        end else if (illegal) begin
            decode_err <= 1'b1;
        end else if (err_clr) begin
            decode_err <= 1'b0;
        end
    end

`ifdef AHB_MUX_ERR_CNT_EN
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            err_cnt <= '0;
        end else if (illegal) begin
            if (err_cnt != '1) begin
                err_cnt <= err_cnt + ERR_CNT_W'(1);
            end
        end else if (err_clr) begin
            err_cnt <= '0;
        end
    end
`endif

    ahb_default_slave u_default_slave (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .illegal (illegal),
        .HREADY  (ds_hready),
        .HRESP   (ds_hresp)
    );

    // dphase_sel is one-hot or zero, so an AND-OR mux is sufficient.
    always_comb begin
        HRDATA_out = '0;
        HREADY_out = ds_hready;
        HRESP_out  = ds_hresp;
        if (dphase_sel != '0) begin
            HREADY_out = 1'b0;
            HRESP_out  = 1'b0;
            for (int i = 0; i < CHANNEL_NUM; i++) begin
                if (dphase_sel[i]) begin
                    HRDATA_out = HRDATA_out | HRDATA_in[i];
                    HREADY_out = HREADY_out | HREADYOUT_in[i];
                    HRESP_out  = HRESP_out  | HRESP_in[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_dphase_mux.sv
// ---------------------------------------------------------------------------
// Testbench for ahb_dphase_mux (CHANNEL_NUM=4, DATA_W=32). HREADY is the
// fed-back HREADY_out. Each table row is one address phase; its expected
// columns describe the data phase seen one clock later.
// ---------------------------------------------------------------------------
module tb_ahb_dphase_mux;

    localparam int CH = 4;
    localparam int DW = 32;
    localparam int CW = 8;

    logic                  hclk = 1'b0;
    logic                  hresetn;
    logic [CH-1:0]         hsel;
    logic [1:0]            htrans;
    logic                  hready;
    logic [CH-1:0][DW-1:0] hrdata_in;
    logic [CH-1:0]         hreadyout_in;
    logic [CH-1:0]         hresp_in;
    logic                  err_clr;
    logic [DW-1:0]         hrdata_out;
    logic                  hready_out;
    logic                  hresp_out;
    logic [CH-1:0]         dphase_sel;
    logic                  decode_err;
`ifdef AHB_MUX_ERR_CNT_EN
    logic [CW-1:0]         err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 hclk = ~hclk;
    assign hready = hready_out;

    ahb_dphase_mux #(.CHANNEL_NUM(CH), .DATA_W(DW), .ERR_CNT_W(CW)) dut (
        .HCLK         (hclk),
        .HRESETn      (hresetn),
        .HSEL_in      (hsel),
        .HTRANS       (htrans),
        .HREADY       (hready),
        .HRDATA_in    (hrdata_in),
        .HREADYOUT_in (hreadyout_in),
        .HRESP_in     (hresp_in),
        .err_clr      (err_clr),
        .HRDATA_out   (hrdata_out),
        .HREADY_out   (hready_out),
        .HRESP_out    (hresp_out),
        .dphase_sel   (dphase_sel),
`ifdef AHB_MUX_ERR_CNT_EN
        .err_cnt      (err_cnt),
`endif
        .decode_err   (decode_err)
    );

    typedef struct {
        logic [3:0]  hsel;
        logic [1:0]  htrans;
        logic        clr;
        logic [3:0]  dsel;
        logic [31:0] rdata;
        logic        rdy;
        logic        resp;
        logic        derr;
        logic [7:0]  cnt;
    } vec_t;

    localparam int NV = 16;
    vec_t vt [NV];

    function automatic vec_t mk(input logic [3:0] hs, input logic [1:0] tr,
                                input logic cl, input logic [3:0] ds,
                                input logic [31:0] rd, input logic ry,
                                input logic rp, input logic de,
                                input logic [7:0] cn);
        vec_t v;
        v.hsel = hs; v.htrans = tr; v.clr = cl; v.dsel = ds; v.rdata = rd;
        v.rdy = ry; v.resp = rp; v.derr = de; v.cnt = cn;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] ds,
                             input logic [31:0] rd, input logic ry,
                             input logic rp, input logic de);
        check({tag, ".dsel"},  32'(dphase_sel), 32'(ds));
        check({tag, ".rdata"}, hrdata_out,      rd);
        check({tag, ".ready"}, 32'(hready_out), 32'(ry));
        check({tag, ".resp"},  32'(hresp_out),  32'(rp));
        check({tag, ".derr"},  32'(decode_err), 32'(de));
    endtask

    initial begin
        // hsel, htrans, clr | dsel, rdata, ready, resp, derr, cnt
        vt[0]  = mk(4'b0100, 2'd2, 0, 4'b0100, 32'hCAFE0002, 1, 0, 0, 0);
        vt[1]  = mk(4'b0001, 2'd3, 0, 4'b0001, 32'hCAFE0000, 1, 0, 0, 0);
        vt[2]  = mk(4'b0000, 2'd0, 0, 4'b0000, 32'h0,        1, 0, 0, 0);
        vt[3]  = mk(4'b0110, 2'd1, 0, 4'b0000, 32'h0,        1, 0, 0, 0);
        vt[4]  = mk(4'b1000, 2'd2, 0, 4'b1000, 32'hCAFE0003, 1, 1, 0, 0);
        vt[5]  = mk(4'b0000, 2'd2, 0, 4'b0000, 32'h0,        0, 1, 1, 1);
        vt[6]  = mk(4'b0010, 2'd2, 0, 4'b0000, 32'h0,        1, 1, 1, 1);
        vt[7]  = mk(4'b0010, 2'd2, 0, 4'b0010, 32'hCAFE0001, 1, 0, 1, 1);
        vt[8]  = mk(4'b0110, 2'd3, 0, 4'b0000, 32'h0,        0, 1, 1, 2);
        vt[9]  = mk(4'b0110, 2'd3, 0, 4'b0000, 32'h0,        1, 1, 1, 2);
        vt[10] = mk(4'b0110, 2'd3, 0, 4'b0000, 32'h0,        0, 1, 1, 3);
        vt[11] = mk(4'b0000, 2'd0, 0, 4'b0000, 32'h0,        1, 1, 1, 3);
        vt[12] = mk(4'b0000, 2'd0, 1, 4'b0000, 32'h0,        1, 0, 0, 0);
        vt[13] = mk(4'b0000, 2'd2, 1, 4'b0000, 32'h0,        0, 1, 1, 1);
        vt[14] = mk(4'b0000, 2'd0, 0, 4'b0000, 32'h0,        1, 1, 1, 1);
        vt[15] = mk(4'b0001, 2'd2, 0, 4'b0001, 32'hCAFE0000, 1, 0, 1, 1);

        for (int i = 0; i < CH; i++) hrdata_in[i] = 32'hCAFE0000 + 32'(i);
        hreadyout_in = '1;
        hresp_in     = 4'b1000;
        hsel         = '0;
        htrans       = 2'd0;
        err_clr      = 1'b0;

        // Reset state
        hresetn = 1'b0;
        #12;
        check_out("reset", 4'b0000, 32'h0, 1, 0, 0);
`ifdef AHB_MUX_ERR_CNT_EN
        check("reset.cnt", 32'(err_cnt), 32'h0);
`endif
        @(negedge hclk);
        hresetn = 1'b1;

        // Table: one address phase per row, check the following data phase
        for (int i = 0; i < NV; i++) begin
            hsel    = vt[i].hsel;
            htrans  = vt[i].htrans;
            err_clr = vt[i].clr;
            @(posedge hclk);
            #1;
            check_out($sformatf("vec%0d", i), vt[i].dsel, vt[i].rdata,
                      vt[i].rdy, vt[i].resp, vt[i].derr);
`ifdef AHB_MUX_ERR_CNT_EN
            check($sformatf("vec%0d.cnt", i), 32'(err_cnt), 32'(vt[i].cnt));
`endif
        end
        err_clr = 1'b0;

        // Wait states from channel 2: select holds, new HSEL_in ignored
        hsel = 4'b0100; htrans = 2'd2;
        @(posedge hclk);
        #1;
        check_out("ws.start", 4'b0100, 32'hCAFE0002, 1, 0, 1);
        hreadyout_in[2] = 1'b0;
        hsel = 4'b0001;
        #1;
        for (int k = 0; k < 3; k++) begin
            check_out($sformatf("ws.wait%0d", k), 4'b0100, 32'hCAFE0002, 0, 0, 1);
            @(posedge hclk);
            #1;
        end
        hreadyout_in[2] = 1'b1;
        #1;
        check_out("ws.release", 4'b0100, 32'hCAFE0002, 1, 0, 1);
        @(posedge hclk);
        #1;
        check_out("ws.next", 4'b0001, 32'hCAFE0000, 1, 0, 1);

        // Reset during the first error cycle abandons the response
        hsel = 4'b0000; htrans = 2'd2;
        @(posedge hclk);
        #1;
        check_out("rst.err1", 4'b0000, 32'h0, 0, 1, 1);
        hresetn = 1'b0;
        #1;
        check_out("rst.async", 4'b0000, 32'h0, 1, 0, 0);
`ifdef AHB_MUX_ERR_CNT_EN
        check("rst.cnt", 32'(err_cnt), 32'h0);
`endif
        hsel = 4'b0001; htrans = 2'd2;
        @(negedge hclk);
        hresetn = 1'b1;
        @(posedge hclk);
        #1;
        check_out("rst.after", 4'b0001, 32'hCAFE0000, 1, 0, 0);
        hsel = 4'b0000; htrans = 2'd0;
        @(posedge hclk);
        #1;
        check_out("rst.idle", 4'b0000, 32'h0, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net: the stimulus is straight-line, this only guards a hang.
    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ahb_dphase_mux.md
AHB_DPHASE_MUX -- requirements
Module: ahb_dphase_mux

Interface
REQ-001 Parameter CHANNEL_NUM, default 4, number of slave channels (2..16).
REQ-002 Parameter DATA_W, default 32, HRDATA width per channel.
REQ-003 Parameter ERR_CNT_W, default 8, decode-error counter width (used only with AHB_MUX_ERR_CNT_EN).
REQ-004 HCLK  in  1  sole clock; all state updates on its rising edge.
REQ-005 HRESETn  in  1  reset, asynchronous assert, active-low.
REQ-006 HSEL_in  in  CHANNEL_NUM  address-phase select from decoder, expected one-hot or zero.
REQ-007 HTRANS  in  2  address-phase transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
REQ-008 HREADY  in  1  bus-wide ready, HREADY_out fed back externally.
REQ-009 HRDATA_in  in  CHANNEL_NUM x DATA_W  per-channel read data.
REQ-010 HREADYOUT_in  in  CHANNEL_NUM  per-channel ready.
REQ-011 HRESP_in  in  CHANNEL_NUM  per-channel response (1 = ERROR).
REQ-012 err_clr  in  1  synchronous clear of decode_err and err_cnt.
REQ-013 HRDATA_out  out  DATA_W; HREADY_out  out  1; HRESP_out  out  1: muxed data-phase response.
REQ-014 dphase_sel  out  CHANNEL_NUM  registered data-phase select.
REQ-015 decode_err  out  1  sticky flag, set on any illegal-select active transfer.
REQ-016 err_cnt  out  ERR_CNT_W  decode-error count (present only with AHB_MUX_ERR_CNT_EN).

Function
REQ-017 Address phase is sampled when HREADY=1: dphase_sel <= HSEL_in if HSEL_in is one-hot, else 0; when HREADY=0, dphase_sel holds.
REQ-018 Illegal access = HREADY=1 and HTRANS[1]=1 and HSEL_in not one-hot (zero or multi-hot).
REQ-019 dphase_sel non-zero: HRDATA_out/HREADY_out/HRESP_out equal channel i's inputs, combinationally, zero added latency.
REQ-020 dphase_sel zero: outputs driven by internal default slave; HRDATA_out = 0 always.
REQ-021 Default slave FSM states DS_IDLE, DS_ERR1, DS_ERR2.
REQ-022 DS_IDLE: HREADY_out=1, HRESP_out=0; illegal access -> DS_ERR1, else stay.
REQ-023 DS_ERR1: HREADY_out=0, HRESP_out=1; unconditionally -> DS_ERR2.
REQ-024 DS_ERR2: HREADY_out=1, HRESP_out=1; illegal access in same cycle -> DS_ERR1, else -> DS_IDLE.
REQ-025 IDLE/BUSY with zero/multi-hot select: zero-wait OKAY, no error logged.
REQ-026 Illegal access sets decode_err in the next cycle; err_clr in same cycle as a new illegal access: set wins.
REQ-027 Legal access sampled in DS_ERR2 -> next cycle selects channel, FSM to DS_IDLE.

Reset
REQ-028 On HRESETn low, immediately: dphase_sel=0, FSM=DS_IDLE, decode_err=0, err_cnt=0; hence HREADY_out=1, HRESP_out=0, HRDATA_out=0.
REQ-029 Reset mid-ERROR-response abandons it; first cycle after release is DS_IDLE.

Configuration
REQ-030 Macro AHB_MUX_ERR_CNT_EN defined: err_cnt port exists, increments by 1 per illegal access, saturates at all-ones, cleared by err_clr (increment wins over clear).
REQ-031 Macro undefined: err_cnt port and counter absent; all other behaviour identical.

Structure
REQ-032 Shared package AHB_package holds htrans_t enum, ds_state_t enum, HRESP_OKAY/HRESP_ERROR constants.
REQ-033 Default-slave FSM is sub-module ahb_default_slave (inputs HCLK, HRESETn, illegal access, outputs HREADY/HRESP); the one-hot check is a package function.

Verification
REQ-034 CHANNEL_NUM=4; HSEL_in=0100, NONSEQ, HREADY=1 -> next cycle dphase_sel=0100, HRDATA_out=HRDATA_in[2]=0xCAFE0002.
REQ-035 Channel 2 holds HREADYOUT_in=0 for 3 cycles -> HREADY_out=0 for 3 cycles, dphase_sel stays 0100, new HSEL_in ignored.
REQ-036 HSEL_in=0000, NONSEQ -> DS_ERR1 (HREADY_out=0,HRESP_out=1) then DS_ERR2 (1,1) then DS_IDLE; decode_err=1.
REQ-037 HSEL_in=0110, SEQ, back-to-back twice -> ERR1,ERR2,ERR1,ERR2; with macro err_cnt=2; err_clr -> 0.
REQ-038 HSEL_in=0000, IDLE -> HREADY_out=1, HRESP_out=0, decode_err stays 0.
REQ-039 HRESETn low during DS_ERR1 -> outputs 1/0/0 at once; after release, legal NONSEQ to channel 0 completes normally.
